// File: rtl/row_clear_sched.sv
// Row-clear / garbage-insert sequencer for the game table; optional attack output
// enabled by defining ROW_CLEAR_ATTACK_EN (send_line is tied low otherwise).
module row_clear_sched #(
    parameter int unsigned ROWS  = 10,
    parameter int unsigned COLS  = 10,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] table_in,
    input  logic                 add_line,
    input  logic [3:0]           garbage_hole,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] table_out,
    output logic [CNT_W-1:0]     lines_cleared,
    output logic [CNT_W-1:0]     pending,
    output logic                 overflow,
    output logic                 send_line
);

    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [2:0] {StIdle, StScan, StShift, StGarb, StDone} state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       work_q, work_d;
    logic [N-1:0]       out_q, out_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   lines_q, lines_d;
    logic [CNT_W-1:0]   pend_q, pend_d;
    logic [3:0]         hole_q, hole_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [N-1:0]       down_work, shift_work, garb_work;
    logic [COLS-1:0]    cur_row, next_row, garb_row;
    logic               garb_dec;

    // Candidate tables for the SHIFT and GARB steps.
    always_comb begin
        down_work = work_q << COLS;
        for (int k = 0; k < ROWS; k++) begin
            if (k <= int'(ptr_q)) begin
                shift_work[k*COLS +: COLS] = down_work[k*COLS +: COLS];
            end else begin
                shift_work[k*COLS +: COLS] = work_q[k*COLS +: COLS];
            end
        end
        garb_row         = '1;
        garb_row[hole_q] = 1'b0;
        garb_work        = work_q >> COLS;
        garb_work[(ROWS-1)*COLS +: COLS] = garb_row;
        cur_row  = work_q[ptr_q*COLS +: COLS];
        next_row = shift_work[ptr_q*COLS +: COLS];
    end

    assign garb_dec = (state_q == StGarb) && (pend_q != '0);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        ptr_d   = ptr_q;
        lines_d = lines_q;
        pend_d  = pend_q;
        hole_d  = hole_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        if (add_line && !garb_dec) begin
            if (pend_q != CntMax) pend_d = pend_q + 1'b1;
        end else if (!add_line && garb_dec) begin
            pend_d = pend_q - 1'b1;
        end
        if (add_line) begin
            hole_d = (garbage_hole >= COLS) ? 4'd0 : garbage_hole;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    work_d  = table_in;
                    ptr_d   = PTR_W'(ROWS - 1);
                    lines_d = '0;
                    ovf_d   = 1'b0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (&cur_row) begin
                    state_d = StShift;
                end else if (ptr_q == '0) begin
                    state_d = StGarb;
                end else begin
                    ptr_d = ptr_q - 1'b1;
                end
            end
            StShift: begin
                work_d = shift_work;
                if (lines_q != CntMax) lines_d = lines_q + 1'b1;
                // The dropped row is re-checked here, so each clear costs one cycle.
                if (&next_row) begin
                    state_d = StShift;
                end else if (ptr_q == '0) begin
                    state_d = StGarb;
                end else begin
                    ptr_d   = ptr_q - 1'b1;
                    state_d = StScan;
                end
            end
            StGarb: begin
                if (pend_q != '0) begin
                    if (|work_q[COLS-1:0]) ovf_d = 1'b1;
                    work_d = garb_work;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_d   = work_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            work_q  <= '0;
            out_q   <= '0;
            ptr_q   <= '0;
            lines_q <= '0;
            pend_q  <= '0;
            hole_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            ptr_q   <= ptr_d;
            lines_q <= lines_d;
            pend_q  <= pend_d;
            hole_q  <= hole_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign table_out     = out_q;
    assign lines_cleared = lines_q;
    assign pending       = pend_q;
    assign overflow      = ovf_q;

`ifdef ROW_CLEAR_ATTACK_EN
    // lines_q is still zero during the first SHIFT of a pass.
    assign send_line = (state_q == StShift) && (lines_q != '0);
`else
    assign send_line = 1'b0;
`endif

endmodule

// File: tb/tb_row_clear_sched.sv
// Directed, table-driven bench for row_clear_sched (default 10x10 geometry).
module tb_row_clear_sched;

    localparam int N = 100;
`ifdef ROW_CLEAR_ATTACK_EN
    localparam bit Attack = 1'b1;
`else
    localparam bit Attack = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, add_line;
    logic [N-1:0] table_in;
    logic [3:0]   garbage_hole;
    logic         busy, done, overflow, send_line;
    logic [N-1:0] table_out;
    logic [3:0]   lines_cleared, pending;

    int n_chk = 0;
    int n_pass = 0;

    row_clear_sched dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .table_in      (table_in),
        .add_line      (add_line),
        .garbage_hole  (garbage_hole),
        .busy          (busy),
        .done          (done),
        .table_out     (table_out),
        .lines_cleared (lines_cleared),
        .pending       (pending),
        .overflow      (overflow),
        .send_line     (send_line)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] tin;
        int           n_add;
        logic [3:0]   hole;
        int           exp_pend;
        logic [N-1:0] exp_tab;
        int           exp_lines;
        int           exp_lat;
        bit           exp_ovf;
        int           exp_sends;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(input logic [N-1:0] tin, input int n_add, input logic [3:0] hole,
                                input int exp_pend, input logic [N-1:0] exp_tab,
                                input int exp_lines, input int exp_lat, input bit exp_ovf,
                                input int exp_sends);
        vec_t v;
        v.tin = tin; v.n_add = n_add; v.hole = hole; v.exp_pend = exp_pend;
        v.exp_tab = exp_tab; v.exp_lines = exp_lines; v.exp_lat = exp_lat;
        v.exp_ovf = exp_ovf; v.exp_sends = exp_sends;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int edges, sends;
        for (int i = 0; i < v.n_add; i++) begin
            add_line = 1'b1; garbage_hole = v.hole;
            @(posedge clk); #1;
        end
        add_line = 1'b0;
        chk($sformatf("v%0d pending_before", idx), N'(pending), N'(v.exp_pend));
        start = 1'b1; table_in = v.tin;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("v%0d busy", idx), N'(busy), N'(1));
        edges = 0; sends = 0;
        while (!done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (send_line) sends++;
        end
        chk($sformatf("v%0d latency", idx), N'(edges), N'(v.exp_lat));
        chk($sformatf("v%0d table_out", idx), table_out, v.exp_tab);
        chk($sformatf("v%0d lines_cleared", idx), N'(lines_cleared), N'(v.exp_lines));
        chk($sformatf("v%0d overflow", idx), N'(overflow), N'(v.exp_ovf));
        chk($sformatf("v%0d pending_after", idx), N'(pending), N'(0));
        chk($sformatf("v%0d send_pulses", idx), N'(sends), N'(v.exp_sends));
        chk($sformatf("v%0d busy_at_done", idx), N'(busy), N'(0));
        @(posedge clk); #1;
        chk($sformatf("v%0d done_one_cycle", idx), N'(done), N'(0));
    endtask

    initial begin
        logic [N-1:0] t, e;
        int edges, dones;

        rst = 1'b1; start = 1'b0; add_line = 1'b0; table_in = '0; garbage_hole = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset busy", N'(busy), N'(0));
        chk("reset done", N'(done), N'(0));
        chk("reset table_out", table_out, '0);
        chk("reset lines", N'(lines_cleared), N'(0));
        chk("reset pending", N'(pending), N'(0));
        chk("reset overflow", N'(overflow), N'(0));
        chk("reset send_line", N'(send_line), N'(0));

        // 0: empty table
        vecs[0] = mk('0, 0, 4'd0, 0, '0, 0, 12, 1'b0, 0);
        // 1: bottom row full, bit 80 drops to bit 90
        t = '0; t[90 +: 10] = 10'h3FF; t[80] = 1'b1; e = '0; e[90] = 1'b1;
        vecs[1] = mk(t, 0, 4'd0, 0, e, 1, 13, 1'b0, 0);
        // 2: rows 9 and 7 full, row 8 = 001
        t = '0; t[90 +: 10] = 10'h3FF; t[80 +: 10] = 10'h001; t[70 +: 10] = 10'h3FF;
        vecs[2] = mk(t, 0, 4'd0, 0, e, 2, 14, 1'b0, Attack ? 1 : 0);
        // 3: two garbage lines, hole 3
        e = '0; e[80 +: 10] = 10'h3F7; e[90 +: 10] = 10'h3F7;
        vecs[3] = mk('0, 2, 4'd3, 2, e, 0, 14, 1'b0, 0);
        // 4: top row occupied + one garbage line (hole 12 -> column 0): top-out
        t = '0; t[0] = 1'b1; e = '0; e[90 +: 10] = 10'h3FE;
        vecs[4] = mk(t, 1, 4'd12, 1, e, 0, 13, 1'b1, 0);
        // 5: clear then insert garbage, hole 5
        t = '0; t[90 +: 10] = 10'h3FF; e = '0; e[90 +: 10] = 10'h3DF;
        vecs[5] = mk(t, 1, 4'd5, 1, e, 1, 14, 1'b0, 0);
        // 6: completely full table
        vecs[6] = mk('1, 0, 4'd0, 0, '0, 10, 22, 1'b0, Attack ? 9 : 0);
        // 7: 17 add_line pulses saturate pending at 15; table fills and tops out
        e = '0;
        for (int r = 0; r < 10; r++) e[r*10 +: 10] = 10'h3FD;
        vecs[7] = mk('0, 17, 4'd1, 15, e, 0, 27, 1'b1, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Second start during SCAN is ignored.
        t = '0; t[90 +: 10] = 10'h3FF; t[80] = 1'b1; e = '0; e[90] = 1'b1;
        start = 1'b1; table_in = t;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (!done && edges < 200) begin
            if (edges == 2) begin start = 1'b1; table_in = '1; end
            @(posedge clk); #1;
            start = 1'b0;
            edges++;
        end
        chk("restart latency", N'(edges), N'(13));
        chk("restart table_out", table_out, e);
        chk("restart lines", N'(lines_cleared), N'(1));

        // Reset mid-SCAN drops everything, including pending.
        add_line = 1'b1; garbage_hole = 4'd2;
        @(posedge clk); #1;
        add_line = 1'b0;
        start = 1'b1; table_in = t;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst busy", N'(busy), N'(0));
        chk("midrst pending", N'(pending), N'(0));
        chk("midrst table_out", table_out, '0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        chk("midrst no_done", N'(dones), N'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
